// File: rtl/coeff_ram_loader.sv
// coeff_ram_loader: 256x16 writable coefficient store, filled by a valid/ready burst loader, with a registered read port.
// Define COEFF_RAM_CHECKSUM_EN to add a running modulo-2^16 checksum of the words accepted in the current burst.
`timescale 1ns/1ps
module coeff_ram_loader #(
  parameter int DATA_W = 16,
  parameter int ADDR_W = 8
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              start,
  input  logic [ADDR_W-1:0] base_addr,
  input  logic [ADDR_W:0]   count,
  input  logic              in_valid,
  input  logic [DATA_W-1:0] in_data,
  output logic              in_ready,
  output logic              busy,
  output logic              done,
  input  logic [ADDR_W-1:0] rd_addr,
  output logic [DATA_W-1:0] rd_data
`ifdef COEFF_RAM_CHECKSUM_EN
  ,
  output logic [DATA_W-1:0] checksum
`endif
);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    LOAD = 2'd1,
    FIN  = 2'd2
  } state_t;

  state_t            state;
  state_t            state_nxt;
  logic [DATA_W-1:0] mem [2**ADDR_W];
  logic [ADDR_W-1:0] wr_ptr;
  logic [ADDR_W:0]   remaining;
  logic              accept;
  logic              xfer;
  logic              we;

  always_ff @(posedge clk) begin
    if (rst) begin
      state <= IDLE;
    end else begin
      state <= state_nxt;
    end
  end

  always_comb begin
    state_nxt = state;
    in_ready  = 1'b0;
    busy      = 1'b0;
    done      = 1'b0;
    accept    = 1'b0;
    xfer      = 1'b0;
    case (state)
      IDLE: begin
        if (start) begin
          accept    = 1'b1;
          state_nxt = (count != '0) ? LOAD : FIN;
        end
      end
      LOAD: begin
        in_ready = 1'b1;
        busy     = 1'b1;
        xfer     = in_valid;
        if (in_valid && (remaining == (ADDR_W+1)'(1))) begin
          state_nxt = FIN;
        end
      end
      FIN: begin
        done      = 1'b1;
        state_nxt = IDLE;
      end
      default: begin
        state_nxt = IDLE;
      end
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      wr_ptr    <= '0;
      remaining <= '0;
    end else if (accept) begin
      wr_ptr    <= base_addr;
      remaining <= count;
    end else if (xfer) begin
      wr_ptr    <= wr_ptr + ADDR_W'(1);
      remaining <= remaining - (ADDR_W+1)'(1);
    end
  end

  // A transfer coinciding with reset is dropped so an aborted burst never writes past its last completed word.
  assign we = xfer && !rst;

  always_ff @(posedge clk) begin
    if (we) begin
      mem[wr_ptr] <= in_data;
    end
  end

  // Old contents are returned when the same address is written on this edge (read-before-write).
  always_ff @(posedge clk) begin
    if (rst) begin
      rd_data <= '0;
    end else begin
      rd_data <= mem[rd_addr];
    end
  end

`ifdef COEFF_RAM_CHECKSUM_EN
  always_ff @(posedge clk) begin
    if (rst) begin
      checksum <= '0;
    end else if (accept) begin
      checksum <= '0;
    end else if (we) begin
      checksum <= checksum + in_data;
    end
  end
`endif

endmodule
